// File: rtl/hanoi_pkg.sv
// -----------------------------------------------------------------------------
// hanoi_pkg
// Shared types and constants for the Tower of Hanoi move generator.
//   rod_t           : 2-bit rod index (rods 0..2)
//   solver_state_e  : IDLE / RUN / DONE
//   ROD_SRC/ROD_DST : rod holding the initial tower / rod holding the final tower
//   MAX_DISKS       : largest supported disk count
//   MOD3_W          : operand width of the mod-3 helper (move index is N+1 bits)
//   map_rod()       : optional 1<->2 rod swap so the tower always ends on rod 2
// -----------------------------------------------------------------------------
package hanoi_pkg;

    typedef logic [1:0] rod_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } solver_state_e;

    localparam rod_t ROD_SRC   = 2'd0;
    localparam rod_t ROD_DST   = 2'd2;
    localparam int   MAX_DISKS = 8;
    localparam int   MOD3_W    = MAX_DISKS + 1;

    // The raw formulas park the tower on rod 2 for odd N and on rod 1 for
    // even N; swapping rods 1 and 2 for even N makes rod 2 the target always.
    function automatic rod_t map_rod(input rod_t raw, input logic swap12);
        rod_t r;
        r = raw;
        if (swap12 && raw == 2'd1) begin
            r = 2'd2;
        end else if (swap12 && raw == 2'd2) begin
            r = 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hanoi_mod3.sv
// -----------------------------------------------------------------------------
// hanoi_mod3
// Combinational remainder modulo 3 of an up-to-9-bit unsigned value.
// Since 4 = 1 (mod 3), the value is congruent to the sum of its 2-bit pairs;
// summing pairs twice collapses the operand to 0..6, resolved by a small case.
// Ports:
//   val  in  [MOD3_W-1:0]  operand
//   rem  out [1:0]         val mod 3
// -----------------------------------------------------------------------------
module hanoi_mod3
    import hanoi_pkg::*;
(
    input  logic [MOD3_W-1:0] val,
    output logic [1:0]        rem
);

    logic [3:0] pair_sum;   // at most 1 + 4*3 = 13
    logic [2:0] fold_sum;   // at most 3 + 3 = 6

    always_comb begin
        pair_sum = 4'(val[8]);
        for (int k = 0; k < 4; k++) begin
            pair_sum = pair_sum + 4'(val[2*k +: 2]);
        end
        fold_sum = 3'(pair_sum[3:2]) + 3'(pair_sum[1:0]);
        case (fold_sum)
            3'd1, 3'd4: rem = 2'd1;
            3'd2, 3'd5: rem = 2'd2;
            default:    rem = 2'd0;
        endcase
    end

endmodule

// File: rtl/hanoi_solver.sv
// -----------------------------------------------------------------------------
// hanoi_solver
// Emits the optimal 2^N-1 move sequence of the N-disk Tower of Hanoi as
// fr/to rod pairs over a valid/ready handshake. The tower starts on rod 0
// and always finishes on rod 2.
// Parameters:
//   N          number of disks, 1..8
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a solve (honoured in IDLE and DONE only)
//   mv_valid   fr/to/disk carry a valid move
//   mv_ready   consumer accepts the move when high with mv_valid
//   fr, to     source / destination rod
//   disk       index of the moved disk (0 = smallest)
//   mv_cnt     1-based index of the current move, holds the last index in DONE
//   busy       high while solving
//   done       high once the sequence has completed
//   err        sticky legality error from the optional rod-state checker
// Configuration macro:
//   HANOI_SOLVER_CHECK_EN  builds a rod-state mirror that flags illegal
//                          moves and an incomplete final tower; when undefined
//                          err is tied low.
// -----------------------------------------------------------------------------
module hanoi_solver
    import hanoi_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         mv_valid,
    input  logic         mv_ready,
    output rod_t         fr,
    output rod_t         to,
    output logic [2:0]   disk,
    output logic [N-1:0] mv_cnt,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int             MW      = N + 1;
    localparam logic [MW-1:0]  M_ONE   = MW'(1);
    localparam logic [MW-1:0]  M_LAST  = MW'((1 << N) - 1);
    localparam logic           SWAP12  = ((N % 2) == 0);

    solver_state_e state_q;
    logic [MW-1:0] m_q;
    logic          mv_valid_q;
    rod_t          fr_q;
    rod_t          to_q;
    logic [2:0]    disk_q;
    logic          busy_q;
    logic          done_q;

    logic          fire;
    logic          is_last;
    logic          start_load;
    logic          load;
    logic [MW-1:0] m_load;
    logic [MW-1:0] m_to_sum;
    logic [1:0]    raw_fr;
    logic [1:0]    raw_to;
    logic [2:0]    nxt_disk;

    assign fire       = (state_q == RUN) && mv_valid_q && mv_ready;
    assign is_last    = (m_q == M_LAST);
    assign start_load = start && (state_q != RUN);

    // Outputs are registered, so the move is computed for the index about to
    // be loaded (1 on start, m+1 on a non-final handshake) rather than for m_q.
    always_comb begin
        load   = 1'b0;
        m_load = m_q + M_ONE;
        if (start_load) begin
            load   = 1'b1;
            m_load = M_ONE;
        end else if (fire && !is_last) begin
            load = 1'b1;
        end
    end

    assign m_to_sum = (m_load | (m_load - M_ONE)) + M_ONE;

    hanoi_mod3 u_mod3_fr (
        .val (MOD3_W'(m_load & (m_load - M_ONE))),
        .rem (raw_fr)
    );

    hanoi_mod3 u_mod3_to (
        .val (MOD3_W'(m_to_sum)),
        .rem (raw_to)
    );

    // Disk index = trailing-zero count of the move index.
    always_comb begin
        nxt_disk = 3'd0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (m_load[i]) begin
                nxt_disk = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            m_q        <= '0;
            mv_valid_q <= 1'b0;
            fr_q       <= '0;
            to_q       <= '0;
            disk_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= RUN;
                        mv_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (fire && is_last) begin
                        state_q    <= DONE;
                        mv_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    mv_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase

            if (load) begin
                m_q    <= m_load;
                fr_q   <= map_rod(raw_fr, SWAP12);
                to_q   <= map_rod(raw_to, SWAP12);
                disk_q <= nxt_disk;
            end
        end
    end

    assign mv_valid = mv_valid_q;
    assign fr       = fr_q;
    assign to       = to_q;
    assign disk     = disk_q;
    assign mv_cnt   = m_q[N-1:0];
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef HANOI_SOLVER_CHECK_EN
    // Rod-state mirror: one N-bit occupancy mask per rod, bit i = disk i.
    logic [N-1:0] st_q [3];
    logic [N-1:0] st_d [3];
    logic [N-1:0] d_mask;
    logic [N-1:0] below_mask;
    logic [N-1:0] st_fr;
    logic [N-1:0] st_to;
    logic         bad_move;
    logic         bad_final;
    logic         err_q;

    assign d_mask     = N'(1) << disk_q;
    assign below_mask = d_mask - N'(1);

    // An out-of-range rod (3) selects an empty mask, which fails the
    // "disk present on source" test and so is reported as illegal.
    always_comb begin
        st_fr = '0;
        st_to = '0;
        for (int r = 0; r < 3; r++) begin
            if (fr_q == 2'(r)) begin
                st_fr = st_q[r];
            end
            if (to_q == 2'(r)) begin
                st_to = st_q[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            st_d[r] = st_q[r];
            if (fr_q == 2'(r)) begin
                st_d[r] = st_d[r] & ~d_mask;
            end
            if (to_q == 2'(r)) begin
                st_d[r] = st_d[r] | d_mask;
            end
        end
    end

    assign bad_move  = ((st_fr & d_mask) == '0)
                     || ((st_fr & below_mask) != '0)
                     || ((st_to & (below_mask | d_mask)) != '0);
    assign bad_final = is_last && (st_d[ROD_DST] != '1);

    always_ff @(posedge clk) begin
        if (rst || start_load) begin
            for (int r = 0; r < 3; r++) begin
                st_q[r] <= (2'(r) == ROD_SRC) ? '1 : '0;
            end
            err_q <= 1'b0;
        end else if (fire) begin
            for (int r = 0; r < 3; r++) begin
                st_q[r] <= st_d[r];
            end
            if (bad_move || bad_final) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
